serial_password_lock_n: RTL and testbench

Parametrised next-generation serial password lock. Accepts one digit per `digit_valid` strobe and compares the entry against a stored user password and a fixed admin password. Counts consecutive failures, enters lockdown after `MAX_ERRORS` failures, and allows password change only from the unlocked state, with an atomic commit. Sits between the keypad debouncer and the indicator LEDs, replacing the fixed 4-digit lock.

---
 rtl/serial_password_lock_n.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_password_lock_n.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_password_lock_n.sv
// Serial password lock: per-digit compare against stored user and fixed admin codes, with lockdown and atomic change.
// All outputs registered; the result of the last digit shows one cycle after it is accepted. No backpressure: every strobe is consumed.
module serial_password_lock_n #(
  parameter int DIGIT_W    = 4,
  parameter int PWD_LEN    = 4,
  parameter int MAX_ERRORS = 3,
  parameter logic [PWD_LEN*DIGIT_W-1:0] ADMIN_PWD = 16'h0129,
  parameter logic [PWD_LEN*DIGIT_W-1:0] RESET_PWD = 16'h0000
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              set_mode,
  input  logic                              digit_valid,
  input  logic [DIGIT_W-1:0]                digit,
  output logic                              unlock_light,
  output logic                              error_light,
  output logic                              warning_light,
  output logic [$clog2(MAX_ERRORS+1)-1:0]   err_count,
  output logic [2:0]                        dbg_state,
  output logic [$clog2(PWD_LEN)-1:0]        dbg_index
);

  localparam int PWD_W = PWD_LEN * DIGIT_W;
  localparam int IDX_W = $clog2(PWD_LEN);
  localparam int CNT_W = $clog2(MAX_ERRORS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PWD_LEN - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_ERRORS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_SET      = 3'd3,
    S_LOCKED   = 3'd4
  } stateT;

  stateT             state, stateNxt;
  logic [IDX_W-1:0]  index, indexNxt;
  logic [CNT_W-1:0]  errCnt, errCntNxt;
  logic              unlockLight, unlockNxt;
  logic              errorLight, errorNxt;
  logic              warnLight, warnNxt;
  logic [PWD_W-1:0]  storedPwd, storedPwdNxt;
  logic [PWD_W-1:0]  shadowPwd, shadowPwdNxt;
  logic              userOk, userOkNxt;
  logic              adminOk, adminOkNxt;

  logic [PWD_W-1:0]  shadowWr;
  logic              userMatch, adminMatch, userMatch0, adminMatch0;
  logic              userHit, adminHit, lockHit;
  logic              beginEntry;
  logic [CNT_W-1:0]  errCntInc;

  // Digit 0 is the most significant digit of a packed password.
  function automatic logic [DIGIT_W-1:0] digitAt(input logic [PWD_W-1:0] pwd,
                                                 input logic [IDX_W-1:0] idx);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < PWD_LEN; i++) begin
      if (idx == IDX_W'(i)) d = pwd[(PWD_LEN-i)*DIGIT_W-1 -: DIGIT_W];
    end
    return d;
  endfunction

  always_comb begin
    shadowWr = shadowPwd;
    for (int i = 0; i < PWD_LEN; i++) begin
      if (index == IDX_W'(i)) shadowWr[(PWD_LEN-i)*DIGIT_W-1 -: DIGIT_W] = digit;
    end
  end

  assign userMatch   = (digit == digitAt(storedPwd, index));
  assign adminMatch  = (digit == digitAt(ADMIN_PWD, index));
  assign userMatch0  = (digit == digitAt(storedPwd, '0));
  assign adminMatch0 = (digit == digitAt(ADMIN_PWD, '0));
  assign userHit     = userOk & userMatch;
  assign adminHit    = adminOk & adminMatch;
  // In lockdown the admin flag restarts on the first digit of each attempt.
  assign lockHit     = ((index == '0) | adminOk) & adminMatch;
  assign errCntInc   = (errCnt < MAX_CNT) ? errCnt + 1'b1 : MAX_CNT;

  always_comb begin
    stateNxt     = state;
    indexNxt     = index;
    errCntNxt    = errCnt;
    unlockNxt    = unlockLight;
    errorNxt     = errorLight;
    warnNxt      = warnLight;
    storedPwdNxt = storedPwd;
    shadowPwdNxt = shadowPwd;
    userOkNxt    = userOk;
    adminOkNxt   = adminOk;
    beginEntry   = 1'b0;

    case (state)
      S_IDLE: begin
        if (digit_valid && !set_mode) beginEntry = 1'b1;
      end

      S_ENTRY: begin
        if (digit_valid) begin
          userOkNxt  = userHit;
          adminOkNxt = adminHit;
          if (index != LAST_IDX) begin
            indexNxt = index + 1'b1;
          end else begin
            indexNxt = '0;
            if (userHit || adminHit) begin
              unlockNxt = 1'b1;
              errCntNxt = '0;
              stateNxt  = S_UNLOCKED;
            end else begin
              errorNxt  = 1'b1;
              errCntNxt = errCntInc;
              if (errCntInc == MAX_CNT) begin
                warnNxt  = 1'b1;
                stateNxt = S_LOCKED;
              end else begin
                stateNxt = S_IDLE;
              end
            end
          end
        end
      end

      S_UNLOCKED: begin
        if (set_mode) begin
          indexNxt     = '0;
          shadowPwdNxt = '0;
          stateNxt     = S_SET;
        end else if (digit_valid) begin
          beginEntry = 1'b1;
        end
      end

      S_SET: begin
        if (!set_mode) begin
          indexNxt     = '0;
          shadowPwdNxt = '0;
          stateNxt     = S_UNLOCKED;
        end else if (digit_valid) begin
          shadowPwdNxt = shadowWr;
          if (index != LAST_IDX) begin
            indexNxt = index + 1'b1;
          end else begin
            // Commit the full new code, including this last digit, in one edge.
            storedPwdNxt = shadowWr;
            shadowPwdNxt = '0;
            indexNxt     = '0;
            unlockNxt    = 1'b0;
            stateNxt     = S_IDLE;
          end
        end
      end

      S_LOCKED: begin
        if (digit_valid) begin
          adminOkNxt = lockHit;
          if (index == '0) errorNxt = 1'b0;
          if (index != LAST_IDX) begin
            indexNxt = index + 1'b1;
          end else begin
            indexNxt = '0;
            if (lockHit) begin
              warnNxt   = 1'b0;
              errCntNxt = '0;
              stateNxt  = S_IDLE;
            end else begin
              errCntNxt = MAX_CNT;
            end
          end
        end
      end

      default: begin
        stateNxt = S_IDLE;
        indexNxt = '0;
      end
    endcase

    if (beginEntry) begin
      unlockNxt  = 1'b0;
      errorNxt   = 1'b0;
      indexNxt   = IDX_W'(1);
      userOkNxt  = userMatch0;
      adminOkNxt = adminMatch0;
      stateNxt   = S_ENTRY;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      index       <= '0;
      errCnt      <= '0;
      unlockLight <= 1'b0;
      errorLight  <= 1'b0;
      warnLight   <= 1'b0;
      storedPwd   <= RESET_PWD;
      shadowPwd   <= '0;
      userOk      <= 1'b0;
      adminOk     <= 1'b0;
    end else begin
      state       <= stateNxt;
      index       <= indexNxt;
      errCnt      <= errCntNxt;
      unlockLight <= unlockNxt;
      errorLight  <= errorNxt;
      warnLight   <= warnNxt;
      storedPwd   <= storedPwdNxt;
      shadowPwd   <= shadowPwdNxt;
      userOk      <= userOkNxt;
      adminOk     <= adminOkNxt;
    end
  end

  assign unlock_light  = unlockLight;
  assign error_light   = errorLight;
  assign warning_light = warnLight;
  assign err_count     = errCnt;
  assign dbg_state     = state;
  assign dbg_index     = index;

endmodule

// File: tb/tb_serial_password_lock_n.sv
// Directed bench for serial_password_lock_n with default parameters (4x4-bit digits, 3 errors, admin 0129).
module tb_serial_password_lock_n;

  logic       CLK;
  logic       RST;
  logic       set_mode;
  logic       digit_valid;
  logic [3:0] digit;
  logic       unlock_light;
  logic       error_light;
  logic       warning_light;
  logic [1:0] err_count;
  logic [2:0] dbg_state;
  logic [1:0] dbg_index;

  int checks = 0;
  int fails  = 0;

  serial_password_lock_n dut (
    .CLK           (CLK),
    .RST           (RST),
    .set_mode      (set_mode),
    .digit_valid   (digit_valid),
    .digit         (digit),
    .unlock_light  (unlock_light),
    .error_light   (error_light),
    .warning_light (warning_light),
    .err_count     (err_count),
    .dbg_state     (dbg_state),
    .dbg_index     (dbg_index)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One-cycle strobe; returns at the falling edge after the accepting edge.
  task automatic sendDigit(input logic [3:0] d);
    @(negedge CLK);
    digit       = d;
    digit_valid = 1'b1;
    @(negedge CLK);
    digit_valid = 1'b0;
  endtask

  task automatic sendCode(input logic [15:0] code);
    for (int i = 0; i < 4; i++) sendDigit(code[15-4*i -: 4]);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++; if (unlock_light !== 1'b0) begin fails++; $display("FAIL reset.unlock got %0b want 0", unlock_light); end
    checks++; if (error_light !== 1'b0) begin fails++; $display("FAIL reset.error got %0b want 0", error_light); end
    checks++; if (warning_light !== 1'b0) begin fails++; $display("FAIL reset.warning got %0b want 0", warning_light); end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL reset.err_count got %0d want 0", err_count); end
    checks++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset.state got %0d want 0", dbg_state); end
    checks++; if (dbg_index !== 2'd0) begin fails++; $display("FAIL reset.index got %0d want 0", dbg_index); end
    RST = 1'b0;
    set_mode = 1'b1;
    sendDigit(4'd0);
    checks++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL idle_setmode.state got %0d want 0", dbg_state); end
    checks++; if (dbg_index !== 2'd0) begin fails++; $display("FAIL idle_setmode.index got %0d want 0", dbg_index); end
    set_mode = 1'b0;
  endtask

  task automatic test_unlock_default;
    sendCode(16'h0000);
    checks++; if (unlock_light !== 1'b1) begin fails++; $display("FAIL unlock_default.unlock got %0b want 1", unlock_light); end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL unlock_default.err_count got %0d want 0", err_count); end
    checks++; if (dbg_state !== 3'd2) begin fails++; $display("FAIL unlock_default.state got %0d want 2", dbg_state); end
    checks++; if (error_light !== 1'b0) begin fails++; $display("FAIL unlock_default.error got %0b want 0", error_light); end
  endtask

  task automatic test_lockout;
    for (int n = 1; n <= 3; n++) begin
      sendCode(16'h1111);
      checks++; if (error_light !== 1'b1) begin fails++; $display("FAIL lockout%0d.error got %0b want 1", n, error_light); end
      checks++; if (err_count !== 2'(n)) begin fails++; $display("FAIL lockout%0d.err_count got %0d want %0d", n, err_count, n); end
      checks++; if (unlock_light !== 1'b0) begin fails++; $display("FAIL lockout%0d.unlock got %0b want 0", n, unlock_light); end
      checks++; if (warning_light !== (n == 3)) begin fails++; $display("FAIL lockout%0d.warning got %0b want %0b", n, warning_light, n == 3); end
      checks++; if (dbg_state !== ((n == 3) ? 3'd4 : 3'd0)) begin fails++; $display("FAIL lockout%0d.state got %0d want %0d", n, dbg_state, (n == 3) ? 4 : 0); end
    end
    sendCode(16'h0000);
    checks++; if (dbg_state !== 3'd4) begin fails++; $display("FAIL locked_user.state got %0d want 4", dbg_state); end
    checks++; if (warning_light !== 1'b1) begin fails++; $display("FAIL locked_user.warning got %0b want 1", warning_light); end
    checks++; if (unlock_light !== 1'b0) begin fails++; $display("FAIL locked_user.unlock got %0b want 0", unlock_light); end
    checks++; if (err_count !== 2'd3) begin fails++; $display("FAIL locked_user.err_count got %0d want 3", err_count); end
    checks++; if (error_light !== 1'b0) begin fails++; $display("FAIL locked_user.error got %0b want 0", error_light); end
  endtask

  task automatic test_admin_recover;
    sendCode(16'h0129);
    checks++; if (warning_light !== 1'b0) begin fails++; $display("FAIL admin_recover.warning got %0b want 0", warning_light); end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL admin_recover.err_count got %0d want 0", err_count); end
    checks++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL admin_recover.state got %0d want 0", dbg_state); end
    checks++; if (unlock_light !== 1'b0) begin fails++; $display("FAIL admin_recover.unlock got %0b want 0", unlock_light); end
    sendCode(16'h0000);
    checks++; if (unlock_light !== 1'b1) begin fails++; $display("FAIL after_recover.unlock got %0b want 1", unlock_light); end
    checks++; if (dbg_state !== 3'd2) begin fails++; $display("FAIL after_recover.state got %0d want 2", dbg_state); end
  endtask

  task automatic test_set_priority;
    @(negedge CLK);
    set_mode    = 1'b1;
    digit       = 4'd5;
    digit_valid = 1'b1;
    @(negedge CLK);
    digit_valid = 1'b0;
    checks++; if (dbg_state !== 3'd3) begin fails++; $display("FAIL set_priority.state got %0d want 3", dbg_state); end
    checks++; if (dbg_index !== 2'd0) begin fails++; $display("FAIL set_priority.index got %0d want 0", dbg_index); end
    set_mode = 1'b0;
    @(negedge CLK);
    checks++; if (dbg_state !== 3'd2) begin fails++; $display("FAIL set_priority_exit.state got %0d want 2", dbg_state); end
  endtask

  task automatic test_set_abort;
    @(negedge CLK);
    set_mode = 1'b1;
    @(negedge CLK);
    checks++; if (dbg_state !== 3'd3) begin fails++; $display("FAIL set_abort_enter.state got %0d want 3", dbg_state); end
    sendDigit(4'd3);
    sendDigit(4'd3);
    checks++; if (dbg_index !== 2'd2) begin fails++; $display("FAIL set_abort_mid.index got %0d want 2", dbg_index); end
    set_mode = 1'b0;
    @(negedge CLK);
    checks++; if (dbg_state !== 3'd2) begin fails++; $display("FAIL set_abort.state got %0d want 2", dbg_state); end
    checks++; if (unlock_light !== 1'b1) begin fails++; $display("FAIL set_abort.unlock got %0b want 1", unlock_light); end
    checks++; if (dbg_index !== 2'd0) begin fails++; $display("FAIL set_abort.index got %0d want 0", dbg_index); end
    sendCode(16'h3300);
    checks++; if (error_light !== 1'b1) begin fails++; $display("FAIL set_abort_partial.error got %0b want 1", error_light); end
    checks++; if (err_count !== 2'd1) begin fails++; $display("FAIL set_abort_partial.err_count got %0d want 1", err_count); end
    sendCode(16'h0000);
    checks++; if (unlock_light !== 1'b1) begin fails++; $display("FAIL set_abort_old.unlock got %0b want 1", unlock_light); end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL set_abort_old.err_count got %0d want 0", err_count); end
  endtask

  task automatic test_set_commit;
    @(negedge CLK);
    set_mode = 1'b1;
    sendCode(16'h5678);
    checks++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL set_commit.state got %0d want 0", dbg_state); end
    checks++; if (unlock_light !== 1'b0) begin fails++; $display("FAIL set_commit.unlock got %0b want 0", unlock_light); end
    sendDigit(4'd5);
    checks++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL commit_hold.state got %0d want 0", dbg_state); end
    checks++; if (dbg_index !== 2'd0) begin fails++; $display("FAIL commit_hold.index got %0d want 0", dbg_index); end
    set_mode = 1'b0;
    sendCode(16'h0000);
    checks++; if (error_light !== 1'b1) begin fails++; $display("FAIL old_pwd.error got %0b want 1", error_light); end
    checks++; if (err_count !== 2'd1) begin fails++; $display("FAIL old_pwd.err_count got %0d want 1", err_count); end
    sendCode(16'h5678);
    checks++; if (unlock_light !== 1'b1) begin fails++; $display("FAIL new_pwd.unlock got %0b want 1", unlock_light); end
    checks++; if (dbg_state !== 3'd2) begin fails++; $display("FAIL new_pwd.state got %0d want 2", dbg_state); end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL new_pwd.err_count got %0d want 0", err_count); end
  endtask

  task automatic test_reset_mid_entry;
    sendCode(16'h1111);
    checks++; if (err_count !== 2'd1) begin fails++; $display("FAIL pre_reset.err_count got %0d want 1", err_count); end
    sendDigit(4'd0);
    repeat (2) @(negedge CLK);
    sendDigit(4'd0);
    checks++; if (dbg_state !== 3'd1) begin fails++; $display("FAIL mid_entry.state got %0d want 1", dbg_state); end
    checks++; if (dbg_index !== 2'd2) begin fails++; $display("FAIL mid_entry.index got %0d want 2", dbg_index); end
    #2 RST = 1'b1;
    #1;
    checks++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL async_reset.state got %0d want 0", dbg_state); end
    checks++; if (dbg_index !== 2'd0) begin fails++; $display("FAIL async_reset.index got %0d want 0", dbg_index); end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL async_reset.err_count got %0d want 0", err_count); end
    checks++; if (error_light !== 1'b0) begin fails++; $display("FAIL async_reset.error got %0b want 0", error_light); end
    checks++; if (unlock_light !== 1'b0 || warning_light !== 1'b0) begin fails++; $display("FAIL async_reset.lights got %0b%0b want 00", unlock_light, warning_light); end
    @(negedge CLK);
    RST = 1'b0;
    sendCode(16'h0000);
    checks++; if (unlock_light !== 1'b1) begin fails++; $display("FAIL reset_pwd.unlock got %0b want 1", unlock_light); end
  endtask

  task automatic test_admin_normal;
    sendCode(16'h1111);
    checks++; if (error_light !== 1'b1) begin fails++; $display("FAIL admin_normal_fail.error got %0b want 1", error_light); end
    checks++; if (err_count !== 2'd1) begin fails++; $display("FAIL admin_normal_fail.err_count got %0d want 1", err_count); end
    sendCode(16'h0129);
    checks++; if (unlock_light !== 1'b1) begin fails++; $display("FAIL admin_normal.unlock got %0b want 1", unlock_light); end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL admin_normal.err_count got %0d want 0", err_count); end
    checks++; if (dbg_state !== 3'd2) begin fails++; $display("FAIL admin_normal.state got %0d want 2", dbg_state); end
  endtask

  initial begin
    RST         = 1'b1;
    set_mode    = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    test_reset();
    test_unlock_default();
    test_lockout();
    test_admin_recover();
    test_set_priority();
    test_set_abort();
    test_set_commit();
    test_reset_mid_entry();
    test_admin_normal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
